funccounter_sched: RTL

Round-robin scheduler that shares one 2-bit function counter between two requesters. The counter advances on `clockin` when its function input is 0 and holds when it is 1; it has no reset. This block drives that function input, runs the counter for a requested number of steps on behalf of the granted requester, and checks the counter's resulting value. It sits beside the counter cell in the same clock domain.

---
 rtl/funccounter_sched_if.sv | 22 ++
 rtl/funccounter_sched.sv | 97 +++++++++
 2 files changed

// File: rtl/funccounter_sched_if.sv
// Requester-side handshake bundle for funccounter_sched.
// Master = requesters, slave = scheduler.
interface funccounter_sched_if;
  logic       req0;
  logic       req1;
  logic [3:0] len0;
  logic [3:0] len1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;

  modport master (
    output req0, req1, len0, len1,
    input  gnt0, gnt1, done0, done1
  );

  modport slave (
    input  req0, req1, len0, len1,
    output gnt0, gnt1, done0, done1
  );
endinterface

// File: rtl/funccounter_sched.sv
// Round-robin scheduler sharing one 2-bit function counter
// between two requesters; checks the counter after each job.
module funccounter_sched (
  input  logic              clockin,
  input  logic              resetin,
  input  logic [1:0]        qin,
  output logic              funcout,
  output logic              busy,
  output logic              err,
  funccounter_sched_if.slave rq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       ptr_q, ptr_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] exp_q, exp_d;
  logic       err_q, err_d;
  logic       pick1;
  logic [3:0] win_len;

  // Winner: lone requester, or the pointed-to one on contention.
  assign pick1   = rq.req1 & (~rq.req0 | ptr_q);
  assign win_len = pick1 ? rq.len1 : rq.len0;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clockin or posedge resetin) begin
    if (resetin) begin
      state  <= IDLE;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      ptr_q  <= 1'b0;
      rem_q  <= 4'd0;
      exp_q  <= 2'd0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      ptr_q  <= ptr_d;
      rem_q  <= rem_d;
      exp_q  <= exp_d;
      err_q  <= err_d;
    end
  end

  // Next-state, grant, step count and end-of-job check.
  always_comb begin
    state_d = state;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    exp_d   = exp_q;
    err_d   = err_q;
    unique case (state)
      IDLE: begin
        if (rq.req0 | rq.req1) begin
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          rem_d   = win_len;
          exp_d   = qin + win_len[1:0];
          state_d = (win_len != 4'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        rem_d = rem_q - 4'd1;
        if (rem_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ptr_d   = gnt0_q;
        err_d   = err_q | (qin != exp_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registers only.
  assign funcout  = (state != RUN);
  assign busy     = (state != IDLE);
  assign err      = err_q;
  assign rq.gnt0  = gnt0_q;
  assign rq.gnt1  = gnt1_q;
  assign rq.done0 = (state == DONE) & gnt0_q;
  assign rq.done1 = (state == DONE) & gnt1_q;

endmodule
